// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider: one quotient bit per clock through a shared trial subtractor.
// Optional DIV_ZERO_DETECT_EN: zero divisor skips iteration and raises dbz.
module div_seq_ctrl #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
`ifdef DIV_ZERO_DETECT_EN
  logic             dbz_q, dbz_d;
`endif

  logic [WIDTH+1:0] trial;
  logic             q_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef DIV_ZERO_DETECT_EN
    dbz_d   = dbz_q;
`endif
    // Partial remainder always stays below 2**WIDTH, so a borrow out of the
    // WIDTH+2-bit difference is equivalent to testing bit WIDTH of the trial.
    trial = {r_q, a_sh_q[WIDTH-1]} - {2'b00, d_q};
    q_bit = ~trial[WIDTH+1];

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = dividend;
          d_d     = divisor;
          r_d     = '0;
          cnt_d   = CW'(WIDTH);
          state_d = S_RUN;
`ifdef DIV_ZERO_DETECT_EN
          if (divisor == '0) begin
            state_d = S_DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end
`endif
        end
      end
      S_RUN: begin
        r_d    = q_bit ? trial[WIDTH:0] : {r_q[WIDTH-1:0], a_sh_q[WIDTH-1]};
        a_sh_d = {a_sh_q[WIDTH-2:0], q_bit};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          quot_d  = a_sh_d;
          rem_d   = r_d[WIDTH-1:0];
`ifdef DIV_ZERO_DETECT_EN
          dbz_d   = 1'b0;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    quotient  = quot_q;
    remainder = rem_q;
`ifdef DIV_ZERO_DETECT_EN
    dbz       = dbz_q;
`else
    dbz       = 1'b0;
`endif
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl (WIDTH=6) against an arithmetic reference model.
module tb_div_seq_ctrl;

  localparam int unsigned W    = 6;
  localparam int          MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division; zero divisor gives all-ones / dividend.
  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? MAXV : a / b;
  endfunction
  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  // Pulse start with the given operands and follow the operation to completion.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bcnt,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic z, output bit seen);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    lat = 0; bcnt = 0; seen = 0; q = '0; r = '0; z = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy) bcnt++;
      if (done) begin
        seen = 1; q = quotient; r = remainder; z = dbz;
        break;
      end
      tick();
      lat++;
    end
    tick();
    if (busy) bcnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; dividend = 6'd45; divisor = 6'd6;
    tick();
    tick();
    checks++;
    if ({busy, done, quotient, remainder, dbz} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b expected all zero",
               busy, done, quotient, remainder, dbz);
    end
    rst = 1'b0; start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_wins_start: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    int lat, bcnt; logic [W-1:0] q, r; logic z; bit seen;
    do_div(6'd45, 6'd6, lat, bcnt, q, r, z, seen);
    checks++;
    if (!seen || lat != W) begin
      failures++;
      $display("FAIL basic_latency: got seen=%0d lat=%0d expected lat=%0d", seen, lat, W);
    end
    checks++;
    if (q !== 6'd7 || r !== 6'd3 || z !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b expected q=7 r=3 dbz=0", q, r, z);
    end
    checks++;
    if (bcnt != W + 1) begin
      failures++;
      $display("FAIL basic_busy_cycles: got %0d expected %0d", bcnt, W + 1);
    end
    checks++;
    if (done !== 1'b0 || quotient !== 6'd7) begin
      failures++;
      $display("FAIL basic_done_single_hold: got done=%b q=%0d expected done=0 q=7", done, quotient);
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] av[5];
    logic [W-1:0] bv[5];
    int lat, bcnt; logic [W-1:0] q, r; logic z; bit seen;
    av = '{6'd63, 6'd5, 6'd63, 6'd0, 6'd1};
    bv = '{6'd1,  6'd9, 6'd63, 6'd7, 6'd63};
    for (int i = 0; i < 5; i++) begin
      do_div(av[i], bv[i], lat, bcnt, q, r, z, seen);
      checks++;
      if (!seen || lat != W || int'(q) != ref_q(av[i], bv[i]) || int'(r) != ref_r(av[i], bv[i])) begin
        failures++;
        $display("FAIL boundary_%0d_%0d: got seen=%0d lat=%0d q=%0d r=%0d expected lat=%0d q=%0d r=%0d",
                 av[i], bv[i], seen, lat, q, r, W, ref_q(av[i], bv[i]), ref_r(av[i], bv[i]));
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt; logic [W-1:0] q, r; logic z; bit seen;
    int exp_lat, exp_busy; logic exp_z;
`ifdef DIV_ZERO_DETECT_EN
    exp_lat = 0; exp_busy = 1; exp_z = 1'b1;
`else
    exp_lat = W; exp_busy = W + 1; exp_z = 1'b0;
`endif
    do_div(6'd37, 6'd0, lat, bcnt, q, r, z, seen);
    checks++;
    if (!seen || lat != exp_lat || bcnt != exp_busy) begin
      failures++;
      $display("FAIL dbz_timing: got seen=%0d lat=%0d busy=%0d expected lat=%0d busy=%0d",
               seen, lat, bcnt, exp_lat, exp_busy);
    end
    checks++;
    if (int'(q) != ref_q(37, 0) || int'(r) != ref_r(37, 0) || z !== exp_z) begin
      failures++;
      $display("FAIL dbz_result: got q=%0d r=%0d dbz=%b expected q=%0d r=%0d dbz=%b",
               q, r, z, ref_q(37, 0), ref_r(37, 0), exp_z);
    end
    do_div(6'd20, 6'd3, lat, bcnt, q, r, z, seen);
    checks++;
    if (q !== 6'd6 || r !== 6'd2 || z !== 1'b0) begin
      failures++;
      $display("FAIL dbz_clears: got q=%0d r=%0d dbz=%b expected q=6 r=2 dbz=0", q, r, z);
    end
  endtask

  task automatic test_busy_protect();
    int pulses = 0;
    int lat, bcnt; logic [W-1:0] q, r; logic z; bit seen;
    logic [W-1:0] q1 = '0, r1 = '0;
    dividend = 6'd45; divisor = 6'd6; start = 1'b1;
    tick();                                    // E0
    start = 1'b0;
    tick();                                    // E1
    dividend = 6'd10; divisor = 6'd3; start = 1'b1;
    tick();                                    // E2: ignored
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        pulses++;
        q1 = quotient; r1 = remainder;
        start = 1'b1;                          // during DONE: ignored
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (pulses != 1 || q1 !== 6'd7 || r1 !== 6'd3) begin
      failures++;
      $display("FAIL busy_protect: got pulses=%0d q=%0d r=%0d expected pulses=1 q=7 r=3", pulses, q1, r1);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_protect_idle: got busy=%b expected 0", busy);
    end
    do_div(6'd10, 6'd3, lat, bcnt, q, r, z, seen);
    checks++;
    if (!seen || q !== 6'd3 || r !== 6'd1) begin
      failures++;
      $display("FAIL busy_protect_next: got seen=%0d q=%0d r=%0d expected q=3 r=1", seen, q, r);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    dividend = 6'd60; divisor = 6'd7; start = 1'b1;
    tick();                                    // E0
    start = 1'b0;
    tick();                                    // E1
    tick();                                    // E2
    rst = 1'b1;
    tick();                                    // E3
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0) begin
      failures++;
      $display("FAIL reset_mid: got busy=%b done=%b q=%0d r=%0d expected 0 0 0 0",
               busy, done, quotient, remainder);
    end
    for (int i = 0; i < 15; i++) begin
      if (done) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL reset_mid_no_done: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_soak();
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] a, b;
    int last_done = -1;
    bit got;
    a = W'($urandom_range(0, MAXV)); b = W'($urandom_range(1, MAXV));
    qa.push_back(a); qb.push_back(b);
    dividend = a; divisor = b; start = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      got = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (done) begin got = 1; break; end
      end
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL soak_timeout: op %0d got no done within 20 cycles expected done", n);
        break;
      end
      a = qa.pop_front(); b = qb.pop_front();
      checks++;
      if (int'(quotient) * int'(b) + int'(remainder) != int'(a) || remainder >= b ||
          int'(quotient) != ref_q(a, b)) begin
        failures++;
        $display("FAIL soak_result: %0d/%0d got q=%0d r=%0d expected q=%0d r=%0d",
                 a, b, quotient, remainder, ref_q(a, b), ref_r(a, b));
      end
      if (last_done >= 0) begin
        checks++;
        if (cyc - last_done != W + 2) begin
          failures++;
          $display("FAIL soak_spacing: got %0d cycles expected %0d", cyc - last_done, W + 2);
        end
      end
      last_done = cyc;
      if (n < 999) begin
        a = W'($urandom_range(0, MAXV)); b = W'($urandom_range(1, MAXV));
        qa.push_back(a); qb.push_back(b);
        dividend = a; divisor = b;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_busy_protect();
    test_reset_mid();
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Iterative restoring-division controller for the 6-bit unsigned divider path. It accepts one operand pair per `start`, then computes one quotient bit per clock through a single shared trial subtractor, stepping WIDTH times. Results and a one-cycle `done` pulse are presented to the Basys3 top-level logic. It replaces the fully unrolled array with a sequenced, area-lean datapath and a clean start/busy/done handshake.

## Interface
- `WIDTH`, default 6: operand, quotient and remainder width in bits; legal range 2–16.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `dividend`  in  WIDTH  unsigned dividend; captured when `start` is accepted.
- `divisor`  in  WIDTH  unsigned divisor; captured when `start` is accepted.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  single-cycle pulse; results are valid in this cycle.
- `quotient`  out  WIDTH  registered quotient; held until the next accepted `start`.
- `remainder`  out  WIDTH  registered remainder; held until the next accepted `start`.
- `dbz`  out  1  divide-by-zero flag; same lifetime as `quotient`.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DONE when the step counter reaches 0.
  - DONE→IDLE unconditionally.
- Internal registers:
  - `a_sh` (WIDTH): dividend shift register, which also collects quotient bits.
  - `r` (WIDTH+1): partial remainder.
  - `d` (WIDTH): latched divisor.
  - `cnt`: ceil(log2(WIDTH+1)) bits.
- Accept in IDLE with `start`=1:
  - `a_sh`←`dividend`, `d`←`divisor`, `r`←0, `cnt`←WIDTH.
  - `quotient`, `remainder` and `dbz` are NOT cleared on accept.
- Each RUN cycle:
  - t = {r[WIDTH-1:0], a_sh[WIDTH-1]} − {1'b0, d}, computed at WIDTH+1 bits.
  - If t[WIDTH]=0: r←t and the new quotient bit is 1. Otherwise r←{r[WIDTH-1:0], a_sh[WIDTH-1]} and the bit is 0.
  - a_sh←{a_sh[WIDTH-2:0], bit}; cnt←cnt−1.
- Leaving RUN:
  - The transition happens on the edge where cnt=1 is consumed.
  - On that edge, `quotient`←final a_sh and `remainder`←final r[WIDTH-1:0].
- DONE: `done`=1 for exactly one cycle; the next edge returns to IDLE.
- `start` in RUN or DONE is ignored and not queued.
- Operand inputs are don't-care except on the accept edge.
- Invariants, checked by the bench:
  - dividend = quotient·divisor + remainder.
  - remainder < divisor whenever divisor ≠ 0.
- Reset at any point: next state IDLE. All outputs take their reset values on that edge, and any in-flight result is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `dbz`=0, state IDLE, `cnt`=0.
- Start accepted at edge E0:
  - `busy`=1 from E0 onward.
  - RUN steps occur at edges E1…E_WIDTH.
  - `done`=1 and the results are valid in the cycle after edge E_WIDTH.
  - State returns to IDLE at E_WIDTH+1, where `busy` falls.
- Throughput: one division every WIDTH+2 cycles when `start` is held high continuously. The first cycle back in IDLE accepts.
- All outputs are registered; there is no combinational path from input to output.
- `rst` and `start` asserted on the same edge: reset wins.

## Configuration
- `DIV_ZERO_DETECT_EN` defined:
  - An accepted `start` with `divisor`=0 bypasses RUN: IDLE→DONE at E0, so `done` is high in the cycle after E0.
  - `quotient`=all ones, `remainder`=`dividend`, `dbz`=1.
  - A non-zero divisor behaves normally and clears `dbz` to 0 at the same point where `quotient` and `remainder` are updated, i.e. on the RUN→DONE edge.
- `DIV_ZERO_DETECT_EN` undefined:
  - No special path; a zero divisor iterates for the full WIDTH cycles.
  - The natural restoring result is quotient all ones and remainder = dividend.
  - `dbz` is constant 0.

## Test plan
- Basic division, WIDTH=6: dividend=45, divisor=6, pulse `start` → `done` 6 cycles after the accept edge with quotient=7, remainder=3, dbz=0; `busy` high for exactly 7 cycles.
- Boundaries: 63/1 → q=63, r=0. 5/9 → q=0, r=5. 63/63 → q=1, r=0. 0/7 → q=0, r=0. Each takes the same 6-cycle latency.
- Divide by zero, 37/0:
  - With `DIV_ZERO_DETECT_EN`: `done` in the cycle after accept, q=63, r=37, dbz=1.
  - Without it: `done` after 6 cycles, q=63, r=37, dbz=0.
- Busy protection: start 45/6, then re-assert `start` with 10/3 at E2 and again during DONE → result is 7 r3 with exactly one `done` pulse; a following IDLE `start` with 10/3 yields q=3, r=1.
- Reset mid-operation: assert `rst` at E3 of 60/7 → next cycle busy=0, done=0, q=0, r=0; no `done` pulse ever appears for 60/7.
- Random soak: 1000 random operand pairs with nonzero divisor, `start` held high → every `done` satisfies the invariants, and pulses are spaced exactly 8 cycles apart.
